muldiv_hilo: RTL
================

# muldiv_hilo

Iterative multiply/divide unit owning the HI/LO register pair of the pipelined MIPS core. Sits beside the EX stage, directly upstream of the ALU. Its `hi`/`lo` outputs drive the ALU's mfhi/mflo operand inputs. It accepts mult/multu/div/divu and mthi/mtlo from EX and raises `busy` so the hazard unit stalls any HI/LO access until the result is written.

## Interface
Parameters:
- `ITER`, 32: iterations per multiply/divide; must equal operand width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  launch operation `op` with operands `a`, `b`.
- `op`  in  2  00 mult, 01 multu, 10 div, 11 divu.
- `a`  in  32  rs value: multiplicand or dividend.
- `b`  in  32  rt value: multiplier or divisor.
- `mthi`  in  1  write `wdata` to HI.
- `mtlo`  in  1  write `wdata` to LO.
- `wdata`  in  32  rs value for mthi/mtlo.
- `hi`  out  32  HI register; feeds ALU mfhi input.
- `lo`  out  32  LO register; feeds ALU mflo input.
- `busy`  out  1  operation in flight; HI/LO not yet valid.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, state IDLE.
- States and transitions:
  - IDLE: `start` moves to CALC. If the op is a multiply and fast multiply is compiled in, it moves to FIX instead.
  - CALC: runs `ITER` cycles, then moves to FIX.
  - FIX: applies sign correction, writes HI/LO, returns to IDLE.
- Operands are captured on the `start` edge. Later changes to `a`/`b` are ignored.
- Signed ops (mult, div):
  - Absolute values are taken at capture and the unsigned core runs on them.
  - In FIX, the product or quotient is negated when sign(a) XOR sign(b).
  - The remainder is negated when sign(a).
- Multiply: shift-add, one multiplier bit per CALC cycle, 64-bit accumulator. HI receives bits [63:32], LO receives bits [31:0].
- Divide: restoring shift-subtract, one quotient bit per CALC cycle. LO receives the quotient, HI the remainder.
- Divide by zero (div or divu): LO=0xFFFFFFFF and HI=`a` as captured. Sign correction is bypassed. Latency is unchanged.
- 0x80000000 / -1 (div): LO=0x80000000, HI=0. No trap.
- mthi/mtlo:
  - Accepted only when `busy`=0; the value is visible on the next cycle.
  - While `busy`=1 they are ignored. The hazard unit must stall them.
- `start` while `busy`=1 is ignored.
- Simultaneous `start` and mthi/mtlo in IDLE: the write is applied, then overwritten by the operation result in FIX.
- `rst` mid-operation: on the next edge the unit returns to IDLE, `busy`=0, HI=LO=0. The partial result is discarded.

## Timing
- The `start` edge is cycle 0.
- Iterative path:
  - `busy`=1 in cycles 1..`ITER`+1 (CALC for `ITER` cycles, then FIX).
  - HI/LO are written on the edge ending FIX.
  - New values and `busy`=0 appear in cycle `ITER`+2 (cycle 34 for `ITER`=32).
- Fast multiply path: `busy`=1 in cycle 1 (FIX) only; result visible in cycle 2.
- `hi`/`lo` are register outputs with no combinational path from inputs.
- `busy` is registered.
- A back-to-back `start` is accepted in the first cycle in which `busy`=0.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - mult/multu use a single-cycle 32x32 combinational multiply, latched at the start edge.
  - Sequence is IDLE→FIX; total latency is 2 cycles.
  - Divide is unchanged.
- `MULDIV_FAST_MUL_EN` undefined: all four ops use the `ITER`-cycle iterative path.

## Structure
- `muldiv_pkg` holds:
  - op encodings (`MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`);
  - the state enum (IDLE, CALC, FIX);
  - the default iteration count.
- Sub-module `muldiv_iter`: a one-step datapath. It performs either a shift-add step or a restoring-subtract step on {acc, operand} and is instantiated once. The FSM, capture logic, sign fix and HI/LO registers stay in `muldiv_hilo`.

## Test plan
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `busy` is high exactly 33 cycles (iterative build) or 1 cycle (fast build).
- mult 0xFFFFFFFD (−3) × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- Divide results:
  - div 0xFFFFFFF9 (−7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 7 ÷ 2 → LO=3, HI=1.
- divu 0x00001234 ÷ 0 → LO=0xFFFFFFFF, HI=0x00001234, same latency as a normal divide.
- Write and start gating:
  - mthi 0xDEADBEEF while idle → `hi`=0xDEADBEEF next cycle.
  - mtlo 0x1 and a second `start` during a divide → both ignored; the divide result is unaffected.
- `rst` asserted in cycle 10 of a divide → next cycle `busy`=0, HI=LO=0. A new divu 100 ÷ 7 then gives LO=14, HI=2.

Source files
------------

// File: rtl/muldiv_pkg.sv
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared op encodings, FSM state type and helpers for muldiv_hilo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

   localparam int MD_ITER_DEFAULT = 32;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   function automatic logic md_is_signed(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_mul(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_MULTU);
   endfunction

   function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
// Module   : muldiv_iter
// Purpose  : One iteration of shift-add multiply or restoring divide on
//            the {acc, operand} pair.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
   parameter int W = 32
) (
   input  logic         div_i,
   input  logic [W-1:0] acc_i,
   input  logic [W-1:0] opnd_i,
   input  logic [W-1:0] m_i,
   output logic [W-1:0] acc_o,
   output logic [W-1:0] opnd_o
);

   logic [W:0]   w_sum;
   logic [W:0]   w_trial;
   logic [W-1:0] w_diff;
   logic         w_ge;

   always_comb begin
      w_sum   = {1'b0, acc_i} + (opnd_i[0] ? {1'b0, m_i} : {(W+1){1'b0}});
      w_trial = {acc_i, opnd_i[W-1]};
      w_ge    = (w_trial >= {1'b0, m_i});
      // Only consumed when trial >= divisor, so the difference fits in W bits
      w_diff  = w_trial[W-1:0] - m_i;
      if (div_i) begin
         acc_o  = w_ge ? w_diff : w_trial[W-1:0];
         opnd_o = {opnd_i[W-2:0], w_ge};
      end else begin
         acc_o  = w_sum[W:1];
         opnd_o = {w_sum[0], opnd_i[W-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_hilo.sv
// ============================================================================
// Module   : muldiv_hilo
// Purpose  : Iterative multiply/divide unit owning HI/LO. Define
//            MULDIV_FAST_MUL_EN for a single-cycle multiply path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_hilo
   import muldiv_pkg::*;
#(
   parameter int ITER = MD_ITER_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy
);

   localparam int c_CW = $clog2(ITER + 1);

   md_state_e         state_q;
   logic [c_CW-1:0]   cnt_q;
   logic [31:0]       acc_q;
   logic [31:0]       opnd_q;
   logic [31:0]       m_q;
   logic [31:0]       a_q;
   logic [31:0]       hi_q;
   logic [31:0]       lo_q;
   logic              div_q;
   logic              negq_q;
   logic              negr_q;
   logic              busy_q;

   logic [31:0]       w_acc_d;
   logic [31:0]       w_opnd_d;
   logic              w_sgn;
   logic [31:0]       w_abs_a;
   logic [31:0]       w_abs_b;
   logic [63:0]       w_prod_fix;
   logic [31:0]       w_quot_fix;
   logic [31:0]       w_rem_fix;

   muldiv_iter #(.W(32)) u_iter (
      .div_i  (div_q),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .m_i    (m_q),
      .acc_o  (w_acc_d),
      .opnd_o (w_opnd_d)
   );

   always_comb begin
      w_sgn      = md_is_signed(op);
      w_abs_a    = md_abs(a, w_sgn);
      w_abs_b    = md_abs(b, w_sgn);
      w_prod_fix = negq_q ? (~{acc_q, opnd_q} + 64'd1) : {acc_q, opnd_q};
      w_quot_fix = negq_q ? (~opnd_q + 32'd1) : opnd_q;
      w_rem_fix  = negr_q ? (~acc_q + 32'd1) : acc_q;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [63:0] w_fast_prod;

   always_comb begin
      if (w_sgn) begin
         w_fast_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      end else begin
         w_fast_prod = {32'd0, a} * {32'd0, b};
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         m_q     <= '0;
         a_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         div_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mthi) hi_q <= wdata;
               if (mtlo) lo_q <= wdata;
               if (start) begin
                  a_q     <= a;
                  m_q     <= w_abs_b;
                  div_q   <= md_is_div(op);
                  negq_q  <= w_sgn & (a[31] ^ b[31]);
                  negr_q  <= w_sgn & a[31];
                  acc_q   <= '0;
                  opnd_q  <= w_abs_a;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CALC;
`ifdef MULDIV_FAST_MUL_EN
                  // Product is already signed-correct; FIX just transfers it
                  if (md_is_mul(op)) begin
                     {acc_q, opnd_q} <= w_fast_prod;
                     negq_q          <= 1'b0;
                     state_q         <= ST_FIX;
                  end
`endif
               end
            end
            ST_CALC: begin
               acc_q  <= w_acc_d;
               opnd_q <= w_opnd_d;
               cnt_q  <= cnt_q + c_CW'(1);
               if (cnt_q == c_CW'(ITER - 1)) state_q <= ST_FIX;
            end
            ST_FIX: begin
               if (div_q) begin
                  if (m_q == 32'd0) begin
                     lo_q <= 32'hFFFF_FFFF;
                     hi_q <= a_q;
                  end else begin
                     lo_q <= w_quot_fix;
                     hi_q <= w_rem_fix;
                  end
               end else begin
                  {hi_q, lo_q} <= w_prod_fix;
               end
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;

endmodule

`default_nettype wire
